divrest_sequencer: RTL and testbench
====================================

# divrest_sequencer

Controller that sits between the core's M-extension execute stage and the 32-cycle restoring divider. It accepts DIV/DIVU/REM/REMU requests over a valid/ready handshake and latches the operands for the whole operation. It drives the divider's start/count/sign inputs, resolves the divide-by-zero and signed-overflow cases without using the datapath, and returns one 32-bit result per request. It also answers a DIV/REM pair on identical operands from a one-entry result cache.

## Interface
- XLEN, 32, operand/result width (only 32 supported)
- ITER, 32, divider iterations per operation
- clk  in  1  clock, rising edge
- rstlow  in  1  asynchronous reset, active low
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept (high only in IDLE)
- req_op  in  2  bit0=1 unsigned, bit1=1 remainder (00 DIV, 01 DIVU, 10 REM, 11 REMU)
- req_a  in  32  dividend (rs1)
- req_b  in  32  divisor (rs2)
- flush  in  1  pipeline kill; aborts any in-flight request
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_data  out  32  quotient or remainder
- div_a, div_b  out  32  latched operands to the divider (stable for the whole operation)
- div_signed  out  1  divider signed mode (high = signed), equal to !op[0]
- div_start  out  1  divider start pulse
- div_count  out  6  divider iteration counter
- div_q, div_r  in  32  divider quotient/remainder, already sign-corrected

## Operation
- Reset values: req_ready=0 during reset and 1 in the first cycle after it. rsp_valid=0, rsp_data=0, div_start=0, div_count=0, div_a=div_b=0, div_signed=0. The cache is invalid.
- States: IDLE, LOAD, RUN, DONE.
- IDLE: req_ready=1. On req_valid, latch op/a/b, then classify:
  - b==0: result = op[1] ? a : 32'hFFFF_FFFF. Go to DONE.
  - signed op, a==32'h8000_0000, b==32'hFFFF_FFFF: result = op[1] ? 0 : 32'h8000_0000. Go to DONE.
  - cache valid, a and b match the cached operands, and op[0] matches the cached op: result = op[1] ? cached r : cached q. Go to DONE.
  - otherwise: go to LOAD.
- LOAD: div_start=1, div_count=0. Go to RUN.
- RUN: div_count increments by 1 per cycle, from 1 to ITER. At count==ITER, capture div_q and div_r into the cache, set the result from op[1], set cache valid, and go to DONE.
- DONE: rsp_valid=1 and rsp_data is held stable. On rsp_ready, go to IDLE.
- Cache: a new divider run overwrites it. Special-case results neither update nor invalidate it. Reset and flush invalidate it.
- flush: takes priority over every transition. Next state is IDLE, rsp_valid drops the next cycle, and div_count returns to 0. A request presented in the same cycle as flush is not accepted.
- A new request is never accepted while rsp_valid=1. There is no back-to-back overlap.

## Timing
- Cycle 0 = request accepted (req_valid & req_ready).
- Divider path: LOAD in cycle 1, RUN in cycles 2..33 (count 1..32), rsp_valid from cycle 34. Latency 34.
- Special-case and cache-hit paths: rsp_valid from cycle 1. Latency 1.
- With rsp_ready tied high, req_ready returns at 35 (divider path) or 2 (fast paths). Throughput is one request per 35 or 2 cycles.
- rsp_valid goes low in the cycle after the handshake.
- When rstlow is asserted mid-operation, all state clears immediately (asynchronous). No response is produced.

## Structure
- Shared package div_pkg:
  - op encodings
  - state enum {IDLE, LOAD, RUN, DONE}
  - constants DIV_BY_ZERO_Q = 32'hFFFF_FFFF, INT_MIN = 32'h8000_0000
- Sub-module div_special_detect: combinational classifier taking op, a, b and producing {is_zero, is_ovf, fast_result}. Reused by the verification model.
- The FSM, counter and cache stay in divrest_sequencer.

## Test plan
- DIVU a=100, b=7: rsp_data=14 at cycle 34. Then REMU with the same operands: rsp_data=2 at cycle 1 (cache hit).
- DIV a=-7 (32'hFFFF_FFF9), b=2: rsp_data=32'hFFFF_FFFD. REM with the same operands returns 32'hFFFF_FFFF via the cache.
- DIV a=5, b=0: rsp_data=32'hFFFF_FFFF at cycle 1. REM a=5, b=0: rsp_data=5. The divider is not started (div_start stays 0).
- DIV a=32'h8000_0000, b=32'hFFFF_FFFF: rsp_data=32'h8000_0000. REM on the same operands: rsp_data=0. DIVU on the same operands: full run, rsp_data=0.
- DIVU 1000/3 with flush at cycle 10: IDLE at cycle 11, no rsp_valid, cache invalid. Repeating the request then takes the full 34 cycles and returns 333.
- rstlow pulsed low in cycle 20 of a run: outputs reach their reset values immediately and req_ready=1 one cycle after release. Holding rsp_ready=0 for 5 cycles keeps rsp_data stable.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the restoring-divider sequencer: op encodings,
// FSM state codes, special-case constants and the classifier result struct.
package div_pkg;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    // State enumeration kept as plain constants so legacy tools read them too.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_LOAD = 2'd1;
    localparam state_t ST_RUN  = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN       = 32'h8000_0000;

    typedef struct packed {
        logic        is_zero;
        logic        is_ovf;
        logic [31:0] fast_result;
    } special_t;

endpackage

// File: rtl/div_special_detect.sv
// Combinational classifier for the operand pairs that never touch the divider:
// divide-by-zero and signed INT_MIN / -1.
module div_special_detect
    import div_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output special_t    special
);

    always_comb begin
        special.is_zero = (b == 32'd0);
        special.is_ovf  = !op[0] && (a == INT_MIN) && (b == DIV_BY_ZERO_Q);
        if (special.is_zero) begin
            special.fast_result = op[1] ? a : DIV_BY_ZERO_Q;
        end else begin
            special.fast_result = op[1] ? 32'd0 : INT_MIN;
        end
    end

endmodule

// File: rtl/divrest_sequencer.sv
// Request sequencer for the 32-cycle restoring divider: handshake, operand
// latching, fast special cases and a one-entry quotient/remainder cache.
module divrest_sequencer
    import div_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rstlow,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic            flush,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic [XLEN-1:0] div_a,
    output logic [XLEN-1:0] div_b,
    output logic            div_signed,
    output logic            div_start,
    output logic [5:0]      div_count,
    input  logic [XLEN-1:0] div_q,
    input  logic [XLEN-1:0] div_r,
    output state_t          dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; valid never waits on ready, and flush blocks acceptance.

    state_t            state_q, state_d;
    logic              init_q, init_d;
    logic [1:0]        op_q, op_d;
    logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
    logic              sgn_q, sgn_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic [5:0]        cnt_q, cnt_d;
    logic              cache_vld_q, cache_vld_d;
    logic [XLEN-1:0]   cache_a_q, cache_a_d, cache_b_q, cache_b_d;
    logic              cache_uns_q, cache_uns_d;
    logic [XLEN-1:0]   cache_quo_q, cache_quo_d, cache_rem_q, cache_rem_d;

    special_t          special;
    logic              accept;
    logic              hit;

    div_special_detect u_special (
        .op      (req_op),
        .a       (req_a),
        .b       (req_b),
        .special (special)
    );

    // init_q holds req_ready low until the first edge after reset release.
    assign req_ready = init_q && (state_q == ST_IDLE);
    assign accept    = req_valid && req_ready && !flush;
    assign hit       = cache_vld_q && (req_a == cache_a_q) && (req_b == cache_b_q)
                       && (req_op[0] == cache_uns_q);

    always_comb begin
        state_d     = state_q;
        init_d      = 1'b1;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        sgn_d       = sgn_q;
        res_d       = res_q;
        cnt_d       = cnt_q;
        cache_vld_d = cache_vld_q;
        cache_a_d   = cache_a_q;
        cache_b_d   = cache_b_q;
        cache_uns_d = cache_uns_q;
        cache_quo_d = cache_quo_q;
        cache_rem_d = cache_rem_q;

        if (flush) begin
            state_d     = ST_IDLE;
            cnt_d       = 6'd0;
            cache_vld_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_d  = req_op;
                        a_d   = req_a;
                        b_d   = req_b;
                        sgn_d = !req_op[0];
                        if (special.is_zero || special.is_ovf) begin
                            res_d   = special.fast_result;
                            state_d = ST_DONE;
                        end else if (hit) begin
                            res_d   = req_op[1] ? cache_rem_q : cache_quo_q;
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    cnt_d   = 6'd1;
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (cnt_q == 6'(ITER)) begin
                        cache_vld_d = 1'b1;
                        cache_a_d   = a_q;
                        cache_b_d   = b_q;
                        cache_uns_d = op_q[0];
                        cache_quo_d = div_q;
                        cache_rem_d = div_r;
                        res_d       = op_q[1] ? div_r : div_q;
                        cnt_d       = 6'd0;
                        state_d     = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstlow) begin
        if (!rstlow) begin
            state_q     <= ST_IDLE;
            init_q      <= 1'b0;
            op_q        <= 2'b00;
            a_q         <= '0;
            b_q         <= '0;
            sgn_q       <= 1'b0;
            res_q       <= '0;
            cnt_q       <= 6'd0;
            cache_vld_q <= 1'b0;
            cache_a_q   <= '0;
            cache_b_q   <= '0;
            cache_uns_q <= 1'b0;
            cache_quo_q <= '0;
            cache_rem_q <= '0;
        end else begin
            state_q     <= state_d;
            init_q      <= init_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sgn_q       <= sgn_d;
            res_q       <= res_d;
            cnt_q       <= cnt_d;
            cache_vld_q <= cache_vld_d;
            cache_a_q   <= cache_a_d;
            cache_b_q   <= cache_b_d;
            cache_uns_q <= cache_uns_d;
            cache_quo_q <= cache_quo_d;
            cache_rem_q <= cache_rem_d;
        end
    end

    assign rsp_valid  = (state_q == ST_DONE);
    assign rsp_data   = res_q;
    assign div_a      = a_q;
    assign div_b      = b_q;
    assign div_signed = sgn_q;
    assign div_start  = (state_q == ST_LOAD);
    assign div_count  = cnt_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_divrest_sequencer.sv
// Bench for divrest_sequencer: behavioural divider stub, scoreboard of expected
// results, latency and cache-behaviour checks, flush and reset scenarios.
module tb_divrest_sequencer;
    import div_pkg::*;

    logic        clk = 1'b0;
    logic        rstlow;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a, req_b;
    logic        flush;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [31:0] div_a, div_b;
    logic        div_signed;
    logic        div_start;
    logic [5:0]  div_count;
    logic [31:0] div_q, div_r;
    state_t      dbg_state;

    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_starts = 0;

    // reference-side cache model
    logic        m_vld;
    logic [31:0] m_a, m_b;
    logic        m_uns;

    always #5 clk = ~clk;

    divrest_sequencer #(.XLEN(32), .ITER(32)) dut (
        .clk        (clk),
        .rstlow     (rstlow),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .flush      (flush),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_signed (div_signed),
        .div_start  (div_start),
        .div_count  (div_count),
        .div_q      (div_q),
        .div_r      (div_r),
        .dbg_state  (dbg_state)
    );

    // external divider stand-in: sign-corrected quotient/remainder
    always_comb begin
        div_q = 32'd0;
        div_r = 32'd0;
        if (div_b != 32'd0) begin
            if (!div_signed) begin
                div_q = div_a / div_b;
                div_r = div_a % div_b;
            end else if (div_a == 32'h8000_0000 && div_b == 32'hFFFF_FFFF) begin
                div_q = 32'h8000_0000;
                div_r = 32'd0;
            end else begin
                div_q = 32'($signed(div_a) / $signed(div_b));
                div_r = 32'($signed(div_a) % $signed(div_b));
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic is_fast(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] model_res(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'd0 : 32'h8000_0000;
        if (op[0]) return op[1] ? (a % b) : (a / b);
        return op[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    endfunction

    // scoreboard: compare on the first cycle of each response
    logic        rsp_seen = 1'b0;
    logic [31:0] mon_exp;
    always @(negedge clk) begin
        if (rstlow) begin
            if (div_start) n_starts++;
            if (rsp_valid && !rsp_seen) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("rsp_data", rsp_data, mon_exp);
                end
            end
        end
        rsp_seen = rsp_valid;
    end

    // called at a negedge; returns at the negedge of cycle 1
    task automatic accept(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output bit ok);
        int w = 0;
        while (!req_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) begin
            check("req_ready_timeout", 32'd0, 32'd1);
            ok = 1'b0;
            return;
        end
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(negedge clk);
        req_valid = 1'b0;
        ok        = 1'b1;
    endtask

    task automatic do_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold);
        logic [31:0] e;
        bit          fast, hit, ok;
        int          lat, exp_lat, s0, w;
        e       = model_res(op, a, b);
        fast    = is_fast(op, a, b);
        hit     = !fast && m_vld && a == m_a && b == m_b && op[0] == m_uns;
        exp_lat = (fast || hit) ? 1 : 34;
        s0      = n_starts;
        exp_q.push_back(e);
        accept(op, a, b, ok);
        if (!ok) begin
            void'(exp_q.pop_back());
            return;
        end
        if (exp_lat == 34) begin
            m_vld = 1'b1;
            m_a   = a;
            m_b   = b;
            m_uns = op[0];
            check("div_start", 32'(div_start), 32'd1);
            check("div_signed", 32'(div_signed), 32'(!op[0]));
        end
        lat = 1;
        while (!rsp_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_data", rsp_data, e);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        w = 0;
        while (rsp_valid && w < 10) begin
            @(negedge clk);
            w++;
        end
        check("rsp_drop", 32'(rsp_valid), 32'd0);
        check("start_count", 32'(n_starts - s0), (exp_lat == 34) ? 32'd1 : 32'd0);
    endtask

    initial begin : main
        bit ok;
        rstlow    = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_a     = 32'd0;
        req_b     = 32'd0;
        flush     = 1'b0;
        rsp_ready = 1'b1;
        m_vld     = 1'b0;
        m_a       = 32'd0;
        m_b       = 32'd0;
        m_uns     = 1'b0;

        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_div_start", 32'(div_start), 32'd0);
        check("rst_div_count", 32'(div_count), 32'd0);
        check("rst_div_a", div_a, 32'd0);
        check("rst_div_b", div_b, 32'd0);
        check("rst_div_signed", 32'(div_signed), 32'd0);
        repeat (3) @(negedge clk);
        rstlow = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(req_ready), 32'd1);

        do_req(OP_DIVU, 32'd100, 32'd7, 0);
        do_req(OP_REMU, 32'd100, 32'd7, 0);
        do_req(OP_DIV,  32'hFFFF_FFF9, 32'd2, 0);
        do_req(OP_REM,  32'hFFFF_FFF9, 32'd2, 0);
        do_req(OP_DIV,  32'd5, 32'd0, 0);
        do_req(OP_REM,  32'd5, 32'd0, 0);
        do_req(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_req(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_req(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_req(OP_DIVU, 32'd1000, 32'd3, 0);

        // flush in cycle 10 of a divider run
        accept(OP_DIVU, 32'd50, 32'd5, ok);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        m_vld = 1'b0;
        check("flush_state", 32'(dbg_state), 32'(ST_IDLE));
        check("flush_rsp_valid", 32'(rsp_valid), 32'd0);
        check("flush_count", 32'(div_count), 32'd0);
        // request alongside flush must be ignored
        req_valid = 1'b1;
        req_op    = OP_DIVU;
        req_a     = 32'd1000;
        req_b     = 32'd3;
        flush     = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        flush     = 1'b0;
        check("flush_blocks_req", 32'(dbg_state), 32'(ST_IDLE));
        do_req(OP_DIVU, 32'd1000, 32'd3, 0);

        for (int i = 0; i < 6; i++) begin
            do_req(2'($urandom_range(0, 3)), 32'($urandom_range(0, 40)),
                   32'($urandom_range(0, 4)), 0);
        end

        // asynchronous reset in cycle 20 of a run
        accept(OP_DIVU, 32'd77, 32'd3, ok);
        repeat (19) @(negedge clk);
        rstlow = 1'b0;
        #1;
        m_vld = 1'b0;
        check("arst_req_ready", 32'(req_ready), 32'd0);
        check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("arst_div_count", 32'(div_count), 32'd0);
        check("arst_div_a", div_a, 32'd0);
        check("arst_rsp_data", rsp_data, 32'd0);
        @(negedge clk);
        rstlow = 1'b1;
        @(negedge clk);
        check("arst_ready_after", 32'(req_ready), 32'd1);

        rsp_ready = 1'b0;
        do_req(OP_DIV, 32'd5, 32'd0, 5);
        do_req(OP_DIVU, 32'd77, 32'd3, 0);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
